// File: rtl/add_intn_serial.sv
// add_intn_serial: multi-cycle WIDTH-bit adder/subtractor that works through
// the operands CHUNK bits per cycle, LSB first. Operands are taken and results
// returned over valid/ready handshakes. The block also reports carry and
// signed overflow, and can optionally saturate the result on overflow.
module add_intn_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             op_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_sat;
    logic             r_amsb;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_ins;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_cin_msb;
    logic             w_cout;
    logic             w_ovf;
    logic             w_accept;

    // Clamp value for a signed overflow: the sign of A gives the direction,
    // because overflow can only happen when the effective operands share a sign.
    function automatic logic signed [WIDTH-1:0] f_sat_limit(input logic neg);
        logic signed [WIDTH-1:0] lim;
        lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return lim;
    endfunction

    // One slice of ripple addition: the low CHUNK bits of A and B, plus the carry.
    always_comb begin
        w_slice    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
        w_ins      = WIDTH'(w_slice[CHUNK-1:0]) << (WIDTH - CHUNK);
        w_res_next = (r_res >> CHUNK) | w_ins;
        // The carry into the top bit is recovered from that bit's sum and its inputs.
        w_cin_msb  = w_slice[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
        w_cout     = w_slice[CHUNK];
        w_ovf      = w_cin_msb ^ w_cout;
        w_last     = (r_state == S_RUN) && (r_cnt == LAST_CNT);
        w_accept   = (r_state == S_IDLE) && in_valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Datapath: load the operands, step one slice per RUN cycle, and register the result on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_sat   <= 1'b0;
            r_amsb  <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_res   <= '0;
            r_carry <= op_sub;
            r_sat   <= op_sat;
            r_amsb  <= a[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_res   <= w_res_next;
            r_carry <= w_cout;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= (r_sat && w_ovf) ? f_sat_limit(r_amsb) : w_res_next;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
